// File: rtl/pipeline_run_ctl.sv
// pipeline_run_ctl
//   Run/step/drain controller for the pipelined RISC-V core. Debounces the RUN
//   and STEP buttons, runs a HALT/RUN/STEP/DRAIN state machine and merges the
//   hazard unit's stall/flush requests into per-stage load enables and flushes.
//   Stage 0 is PC/fetch, stage STAGES-1 is writeback.
//
// Parameters
//   STAGES           number of pipeline stages (>=2)
//   DEBOUNCE_CYCLES  cycles a synchronised button level must hold (>=2)
//   STEP_W           width of the step counter
//
// Ports
//   i_clk          clock
//   i_rst          asynchronous active-low reset
//   i_btn_run      raw RUN button (asynchronous)
//   i_btn_step     raw STEP button (asynchronous)
//   i_step_count   fetch advances per STEP press (0 behaves as 1)
//   i_halt_req     level halt request (exception / ebreak)
//   i_stall_req    per-stage stall request
//   i_flush_req    per-stage flush request
//   o_stage_en     pipeline register load enables
//   o_stage_flush  pipeline register clear-to-bubble
//   o_state        00 HALT, 01 RUN, 10 STEP, 11 DRAIN
//   o_steps_left   remaining STEP fetch advances
//   o_halted       state is HALT
//   o_cycle_cnt    writeback advance counter
//
// Build option
//   PIPE_RUN_CTL_CYCLE_CNT_EN  when defined, o_cycle_cnt counts cycles with
//                              writeback enabled (wrapping); otherwise it is 0.

module pipeline_run_ctl #(
  parameter int STAGES          = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_btn_run,
  input  logic              i_btn_step,
  input  logic [STEP_W-1:0] i_step_count,
  input  logic              i_halt_req,
  input  logic [STAGES-1:0] i_stall_req,
  input  logic [STAGES-1:0] i_flush_req,
  output logic [STAGES-1:0] o_stage_en,
  output logic [STAGES-1:0] o_stage_flush,
  output logic [1:0]        o_state,
  output logic [STEP_W-1:0] o_steps_left,
  output logic              o_halted,
  output logic [31:0]       o_cycle_cnt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DRN_W = $clog2(STAGES);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_DRAIN = 2'b11
  } state_t;

  // ---- button synchronise + debounce (bit 0 = RUN, bit 1 = STEP) ----
  logic [1:0]            btn_raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] dbc_q, dbc_d;

  assign btn_raw = {i_btn_step, i_btn_run};

  // The counter tracks consecutive samples that disagree with the accepted
  // level; any agreeing sample restarts it, so short glitches never land.
  always_comb begin
    lvl_d   = lvl_q;
    press_d = '0;
    dbc_d   = '0;
    for (int b = 0; b < 2; b++) begin
      if (sync2_q[b] != lvl_q[b]) begin
        if (dbc_q[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          dbc_d[b] = dbc_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      press_q <= '0;
      dbc_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      press_q <= press_d;
      dbc_q   <= dbc_d;
    end
  end

  // ---- stage activity, enables and flushes (combinational) ----
  state_t              state_q, state_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [DRN_W-1:0]    drain_q, drain_d;
  logic [STAGES-1:0]   g;
  logic [STAGES-1:0]   stage_en;
  logic                stall_acc;

  always_comb begin
    case (state_q)
      ST_RUN, ST_STEP: g = '1;
      ST_DRAIN:        g = {{(STAGES-1){1'b1}}, 1'b0};
      default:         g = '0;
    endcase
  end

  // A stall freezes its own stage and every earlier one, so sweep from
  // writeback toward fetch accumulating stall requests.
  always_comb begin
    stage_en  = '0;
    stall_acc = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      stall_acc   = stall_acc | i_stall_req[i];
      stage_en[i] = g[i] & ~stall_acc;
    end
  end

  assign o_stage_en    = stage_en;
  assign o_stage_flush = g & i_flush_req;

  // ---- run/step/drain state machine ----
  logic run_p, step_p;
  assign run_p  = press_q[0];
  assign step_p = press_q[1];

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    drain_d = drain_q;
    if (i_halt_req) begin
      state_d = ST_HALT;
      steps_d = '0;
      drain_d = '0;
    end else begin
      case (state_q)
        ST_HALT: begin
          // run wins over a simultaneous step press
          if (run_p) begin
            state_d = ST_RUN;
          end else if (step_p) begin
            state_d = ST_STEP;
            steps_d = (i_step_count == '0) ? STEP_W'(1) : i_step_count;
          end
        end
        ST_RUN: begin
          if (run_p) begin
            state_d = ST_DRAIN;
            drain_d = DRN_W'(STAGES - 1);
          end
        end
        ST_STEP: begin
          if (run_p) begin
            state_d = ST_RUN;
            steps_d = '0;
          end else if (stage_en[0] && steps_q != '0) begin
            steps_d = steps_q - 1'b1;
            if (steps_q == STEP_W'(1)) begin
              state_d = ST_DRAIN;
              drain_d = DRN_W'(STAGES - 1);
            end
          end
        end
        ST_DRAIN: begin
          if (stage_en[STAGES-1] && drain_q != '0) begin
            drain_d = drain_q - 1'b1;
            if (drain_q == DRN_W'(1)) state_d = ST_HALT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_HALT;
      steps_q <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      steps_q <= steps_d;
      drain_q <= drain_d;
    end
  end

  assign o_state      = state_q;
  assign o_steps_left = steps_q;
  assign o_halted     = (state_q == ST_HALT);

  // ---- optional writeback advance counter ----
`ifdef PIPE_RUN_CTL_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cyc_q <= '0;
    end else if (stage_en[STAGES-1]) begin
      cyc_q <= cyc_q + 32'd1;
    end
  end

  assign o_cycle_cnt = cyc_q;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_run_ctl.sv
module tb_pipeline_run_ctl;

  localparam int S  = 5;
  localparam int D  = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_btn_run = 1'b0;
  logic          i_btn_step = 1'b0;
  logic [SW-1:0] i_step_count = '0;
  logic          i_halt_req = 1'b0;
  logic [S-1:0]  i_stall_req = '0;
  logic [S-1:0]  i_flush_req = '0;
  logic [S-1:0]  o_stage_en;
  logic [S-1:0]  o_stage_flush;
  logic [1:0]    o_state;
  logic [SW-1:0] o_steps_left;
  logic          o_halted;
  logic [31:0]   o_cycle_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_run_ctl #(.STAGES(S), .DEBOUNCE_CYCLES(D), .STEP_W(SW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_btn_run    (i_btn_run),
    .i_btn_step   (i_btn_step),
    .i_step_count (i_step_count),
    .i_halt_req   (i_halt_req),
    .i_stall_req  (i_stall_req),
    .i_flush_req  (i_flush_req),
    .o_stage_en   (o_stage_en),
    .o_stage_flush(o_stage_flush),
    .o_state      (o_state),
    .o_steps_left (o_steps_left),
    .o_halted     (o_halted),
    .o_cycle_cnt  (o_cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Accepted button level flips once the last D synchronised samples (raw
  // samples delayed by two clocks) all disagree with it.
  typedef struct packed {
    logic [1:0]    st;
    logic [SW-1:0] steps;
    logic [7:0]    drain;
    logic [31:0]   cyc;
    logic [D+1:0]  hr;
    logic [D+1:0]  hs;
    logic          acc_r;
    logic          acc_s;
    logic          pr_r;
    logic          pr_s;
  } mdl_t;

  mdl_t m = '0;

  function automatic logic [S-1:0] exp_g(input logic [1:0] st);
    if (st == 2'b01 || st == 2'b10) return '1;
    if (st == 2'b11) return ~S'(1);
    return '0;
  endfunction

  function automatic logic [S-1:0] exp_en(input logic [1:0] st, input logic [S-1:0] stall);
    logic [S-1:0] e;
    e = exp_g(st);
    for (int i = 0; i < S; i++)
      if ((stall >> i) != '0) e[i] = 1'b0;
    return e;
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input logic br, input logic bs,
                                 input logic [SW-1:0] cnt, input logic halt,
                                 input logic [S-1:0] stall);
    mdl_t n;
    logic [S-1:0] en;
    n  = c;
    en = exp_en(c.st, stall);
`ifdef PIPE_RUN_CTL_CYCLE_CNT_EN
    if (en[S-1]) n.cyc = c.cyc + 32'd1;
`endif
    if (halt) begin
      n.st = 2'b00; n.steps = '0; n.drain = '0;
    end else if (c.st == 2'b00) begin
      if (c.pr_r) n.st = 2'b01;
      else if (c.pr_s) begin
        n.st = 2'b10;
        n.steps = (cnt == 0) ? SW'(1) : cnt;
      end
    end else if (c.st == 2'b01) begin
      if (c.pr_r) begin n.st = 2'b11; n.drain = 8'(S - 1); end
    end else if (c.st == 2'b10) begin
      if (c.pr_r) begin
        n.st = 2'b01; n.steps = '0;
      end else if (en[0] && c.steps > 0) begin
        n.steps = c.steps - 1;
        if (n.steps == 0) begin n.st = 2'b11; n.drain = 8'(S - 1); end
      end
    end else begin
      if (en[S-1] && c.drain > 0) begin
        n.drain = c.drain - 1;
        if (n.drain == 0) n.st = 2'b00;
      end
    end
    n.hr = {c.hr[D:0], br};
    n.hs = {c.hs[D:0], bs};
    n.pr_r = 1'b0;
    n.pr_s = 1'b0;
    if (n.hr[D+1:2] == {D{~c.acc_r}}) begin n.acc_r = ~c.acc_r; n.pr_r = n.acc_r; end
    if (n.hs[D+1:2] == {D{~c.acc_s}}) begin n.acc_s = ~c.acc_s; n.pr_s = n.acc_s; end
    return n;
  endfunction

  always @(posedge clk or negedge i_rst) begin
    if (!i_rst) m <= '0;
    else m <= mstep(m, i_btn_run, i_btn_step, i_step_count, i_halt_req, i_stall_req);
  end

  // compare every cycle on the inactive edge
  always @(negedge clk) begin
    chk("state",      32'(o_state),       32'(m.st));
    chk("halted",     32'(o_halted),      32'(m.st == 2'b00));
    chk("steps_left", 32'(o_steps_left),  32'(m.steps));
    chk("stage_en",   32'(o_stage_en),    32'(exp_en(m.st, i_stall_req)));
    chk("stage_fl",   32'(o_stage_flush), 32'(exp_g(m.st) & i_flush_req));
    chk("cycle_cnt",  o_cycle_cnt,        m.cyc);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(3);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_halted", 32'(o_halted), 32'd1);
    chk("rst_en", 32'(o_stage_en), 32'd0);
    chk("rst_cyc", o_cycle_cnt, 32'd0);
    i_rst = 1'b1;
    cyc(2);

    // 5-cycle glitch: no press
    i_btn_run = 1'b1;
    cyc(5);
    i_btn_run = 1'b0;
    cyc(30);
    chk("glitch_state", 32'(o_state), 32'd0);

    // held 20 cycles: RUN on the 19th edge
    i_btn_run = 1'b1;
    cyc(18);
    chk("run_lat_pre", 32'(o_state), 32'd0);
    cyc(1);
    chk("run_lat", 32'(o_state), 32'b01);
    chk("run_en", 32'(o_stage_en), 32'b11111);
    chk("run_halted", 32'(o_halted), 32'd0);
    cyc(1);
    i_btn_run = 1'b0;
    cyc(25);

    // stall and flush in RUN
    i_stall_req = 5'b00100;
    #1;
    chk("stall_en", 32'(o_stage_en), 32'b11000);
    i_flush_req = 5'b00100;
    #1;
    chk("flush", 32'(o_stage_flush), 32'b00100);
    cyc(1);
    i_stall_req = '0;
    i_flush_req = '0;
    cyc(1);

    // halt request together with a run press in RUN -> HALT
    i_btn_run = 1'b1;
    cyc(18);
    i_halt_req = 1'b1;
    cyc(1);
    chk("halt_vs_run", 32'(o_state), 32'd0);
    i_halt_req = 1'b0;
    i_btn_run  = 1'b0;
    cyc(25);

    // step 3 with no stalls: 3 fetch + 4 drain cycles
    i_step_count = 8'd3;
    i_btn_step = 1'b1;
    cyc(19);
    chk("step_state", 32'(o_state), 32'b10);
    chk("step_left", 32'(o_steps_left), 32'd3);
    i_btn_step = 1'b0;
    cyc(3);
    chk("step_drain", 32'(o_state), 32'b11);
    cyc(3);
    chk("step_drain_end", 32'(o_state), 32'b11);
    cyc(1);
    chk("step_halt", 32'(o_state), 32'd0);
    cyc(20);

    // step 3 with a 2-cycle stage-0 stall: 2 extra cycles
    i_btn_step = 1'b1;
    cyc(19);
    i_btn_step = 1'b0;
    i_stall_req = 5'b00001;
    cyc(2);
    i_stall_req = '0;
    chk("stall_step_left", 32'(o_steps_left), 32'd3);
    cyc(6);
    chk("stall_step_drain", 32'(o_state), 32'b11);
    cyc(1);
    chk("stall_step_halt", 32'(o_state), 32'd0);
    cyc(20);

    // step count 0 behaves as 1
    i_step_count = 8'd0;
    i_btn_step = 1'b1;
    cyc(19);
    chk("step0_left", 32'(o_steps_left), 32'd1);
    i_btn_step = 1'b0;
    cyc(1);
    chk("step0_drain", 32'(o_state), 32'b11);
    cyc(3);
    chk("step0_drain_end", 32'(o_state), 32'b11);
    cyc(1);
    chk("step0_halt", 32'(o_state), 32'd0);
    cyc(20);

    // simultaneous run and step press: run wins
    i_step_count = 8'd2;
    i_btn_run  = 1'b1;
    i_btn_step = 1'b1;
    cyc(19);
    chk("both_state", 32'(o_state), 32'b01);
    chk("both_steps", 32'(o_steps_left), 32'd0);
    i_btn_run  = 1'b0;
    i_btn_step = 1'b0;
    cyc(25);

    // enter DRAIN, hold it with a writeback stall, then async reset
    i_btn_run = 1'b1;
    cyc(19);
    chk("drain_state", 32'(o_state), 32'b11);
    i_btn_run = 1'b0;
    i_stall_req = 5'b10000;
    cyc(2);
    chk("drain_hold", 32'(o_state), 32'b11);
    #2;
    i_rst = 1'b0;
    #1;
    chk("arst_state", 32'(o_state), 32'd0);
    chk("arst_halted", 32'(o_halted), 32'd1);
    chk("arst_en", 32'(o_stage_en), 32'd0);
    chk("arst_steps", 32'(o_steps_left), 32'd0);
    chk("arst_cyc", o_cycle_cnt, 32'd0);
    i_stall_req = '0;
    cyc(3);
    i_rst = 1'b1;
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
